// File: rtl/uart_tx.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx
// Brief    : Asynchronous serial transmitter. Sends start, 8 data bits LSB
//            first, optional parity and one stop bit, then pulses txDone.
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx #(
    parameter int CLKS_PER_BIT = 434,
    parameter int PARITY       = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       txEn,
    input  logic [7:0] data_tx,
    output logic       tx,
    output logic       txDone,
    output logic       busy
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_PARITY = 3'd3;
    localparam logic [2:0] S_STOP   = 3'd4;
    localparam logic [2:0] S_DONE   = 3'd5;

    logic [2:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic [2:0]       idx_q,   idx_d;
    logic [7:0]       shift_q, shift_d;
    logic             par_q,   par_d;
    logic             tx_q,    tx_d;
    logic             done_q,  done_d;
    logic             busy_q,  busy_d;

    logic bit_end;
    logic par_fold;
    logic par_bit;

    assign bit_end  = (cnt_q == CNT_MAX);
    // shift_q[0] holds bit 7 when the last data bit ends, so this is the full XOR
    assign par_fold = par_q ^ shift_q[0];
    assign par_bit  = (PARITY == 2) ? ~par_fold : par_fold;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            par_q   <= 1'b0;
            tx_q    <= 1'b1;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            par_q   <= par_d;
            tx_q    <= tx_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        par_d   = par_q;
        case (state_q)
            S_IDLE: begin
                if (txEn) begin
                    state_d = S_START;
                    cnt_d   = '0;
                    idx_d   = '0;
                    shift_d = data_tx;
                    par_d   = 1'b0;
                end
            end
            S_START, S_PARITY, S_STOP: begin
                if (bit_end) begin
                    cnt_d = '0;
                    case (state_q)
                        S_START:  state_d = S_DATA;
                        S_PARITY: state_d = S_STOP;
                        default:  state_d = S_DONE;
                    endcase
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    cnt_d = '0;
                    par_d = par_fold;
                    if (idx_q != 3'd7) begin
                        idx_d   = idx_q + 3'd1;
                        shift_d = {1'b0, shift_q[7:1]};
                    end else begin
                        state_d = (PARITY != 0) ? S_PARITY : S_STOP;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        tx_d   = tx_q;
        done_d = 1'b0;
        busy_d = busy_q;
        case (state_q)
            S_IDLE: begin
                tx_d   = ~txEn;
                busy_d = txEn;
            end
            S_START: begin
                if (bit_end) tx_d = shift_q[0];
            end
            S_DATA: begin
                if (bit_end) begin
                    if (idx_q != 3'd7) tx_d = shift_q[1];
                    else               tx_d = (PARITY != 0) ? par_bit : 1'b1;
                end
            end
            S_PARITY: begin
                if (bit_end) tx_d = 1'b1;
            end
            S_STOP: begin
                if (bit_end) done_d = 1'b1;
            end
            default: begin
                tx_d   = 1'b1;
                busy_d = 1'b0;
            end
        endcase
    end

    assign tx     = tx_q;
    assign txDone = done_q;
    assign busy   = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_tx
// Brief    : Bench for uart_tx; three instances (no/even/odd parity) share
//            stimulus, each checked cycle-by-cycle against queued bytes.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_tx;

    localparam int CPB = 4;

    logic       clk     = 1'b0;
    logic       rst_n   = 1'b1;
    logic       txEn    = 1'b0;
    logic [7:0] data_tx = 8'h00;
    logic       tx_w   [3];
    logic       done_w [3];
    logic       busy_w [3];

    int n_chk  = 0;
    int n_pass = 0;

    logic [7:0] q0[$];
    logic [7:0] q1[$];
    logic [7:0] q2[$];

    always #5 clk = ~clk;

    for (genvar p = 0; p < 3; p++) begin : g_dut
        uart_tx #(
            .CLKS_PER_BIT(CPB),
            .PARITY      (p)
        ) u_dut (
            .clk    (clk),
            .rst_n  (rst_n),
            .txEn   (txEn),
            .data_tx(data_tx),
            .tx     (tx_w[p]),
            .txDone (done_w[p]),
            .busy   (busy_w[p])
        );
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic push_all(input logic [7:0] b);
        q0.push_back(b);
        q1.push_back(b);
        q2.push_back(b);
    endtask

    task automatic pop_exp(input int p, output logic ok, output logic [7:0] b);
        ok = 1'b0;
        b  = 8'h00;
        case (p)
            0: if (q0.size() > 0) begin b = q0.pop_front(); ok = 1'b1; end
            1: if (q1.size() > 0) begin b = q1.pop_front(); ok = 1'b1; end
            default: if (q2.size() > 0) begin b = q2.pop_front(); ok = 1'b1; end
        endcase
    endtask

    // Expected line level k cycles after the accepting edge
    function automatic logic exp_tx(input int p, input int k, input logic [7:0] b);
        int bit_n;
        bit_n = k / CPB;
        if (bit_n == 0) return 1'b0;
        if (bit_n <= 8) return b[bit_n-1];
        if (p != 0 && bit_n == 9) return (^b) ^ (p == 2);
        return 1'b1;
    endfunction

    task automatic mon(input int p);
        int         k;
        int         last;
        logic [7:0] b;
        logic       ok;
        k    = -1;
        b    = 8'h00;
        last = (p == 0) ? 10*CPB : 11*CPB;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                k = -1;
                chk($sformatf("d%0d_rst_tx", p), tx_w[p], 1);
                chk($sformatf("d%0d_rst_done", p), done_w[p], 0);
                chk($sformatf("d%0d_rst_busy", p), busy_w[p], 0);
            end else begin
                if (k < 0) begin
                    if (busy_w[p]) begin
                        pop_exp(p, ok, b);
                        chk($sformatf("d%0d_frame_expected", p), ok, 1);
                        k = 0;
                    end else begin
                        chk($sformatf("d%0d_idle_tx", p), tx_w[p], 1);
                        chk($sformatf("d%0d_idle_done", p), done_w[p], 0);
                    end
                end
                if (k >= 0) begin
                    chk($sformatf("d%0d_tx byte %0h k=%0d", p, b, k), tx_w[p], exp_tx(p, k, b));
                    chk($sformatf("d%0d_done k=%0d", p, k), done_w[p], (k == last));
                    chk($sformatf("d%0d_busy k=%0d", p, k), busy_w[p], 1);
                    k = (k == last) ? -1 : k + 1;
                end
            end
        end
    endtask

    task automatic send(input logic [7:0] b);
        @(negedge clk);
        data_tx = b;
        txEn    = 1'b1;
        push_all(b);
        @(negedge clk);
        txEn = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((busy_w[0] | busy_w[1] | busy_w[2]) && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("idle_timeout", n < 200, 1);
    endtask

    task automatic wait_done0(input string tag);
        int n;
        n = 0;
        while (!done_w[0] && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk(tag, n < 100, 1);
    endtask

    initial begin
        fork
            mon(0);
            mon(1);
            mon(2);
        join_none

        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);

        send(8'hA5);
        wait_idle();
        send(8'h07);
        wait_idle();

        // Controller-style handshake: hold until txDone, drop, re-raise a cycle later
        @(negedge clk);
        data_tx = 8'h00;
        txEn    = 1'b1;
        push_all(8'h00);
        wait_done0("hs_done1_timeout");
        txEn = 1'b0;
        @(negedge clk);
        chk("hs_gap_busy", busy_w[0], 0);
        chk("hs_gap_tx", tx_w[0], 1);
        data_tx = 8'hFF;
        txEn    = 1'b1;
        push_all(8'hFF);
        @(negedge clk);
        chk("hs_start_tx", tx_w[0], 0);
        chk("hs_start_busy", busy_w[0], 1);
        wait_done0("hs_done2_timeout");
        txEn = 1'b0;
        wait_idle();

        // Inputs wiggled mid-frame must not disturb the latched byte
        send(8'hC3);
        repeat (20) begin
            @(negedge clk);
            data_tx = 8'($urandom);
            txEn    = ~txEn;
        end
        txEn = 1'b0;
        wait_idle();

        // Reset in the middle of a frame
        send(8'h3C);
        repeat (17) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        for (int p = 0; p < 3; p++) begin
            chk($sformatf("rst_mid_tx%0d", p), tx_w[p], 1);
            chk($sformatf("rst_mid_done%0d", p), done_w[p], 0);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        send(8'h55);
        wait_idle();
        repeat (5) @(negedge clk);

        chk("q0_left", q0.size(), 0);
        chk("q1_left", q1.size(), 0);
        chk("q2_left", q2.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "simulation time limit reached");
    end

endmodule
`default_nettype wire
